// File: rtl/apple1_bus_ctrl_pkg.sv
// Shared definitions for the Apple-1 CPU-side bus controller: FSM encoding,
// default memory map and the open-bus read value.
package apple1_bus_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } state_t;

   localparam logic [15:0] RAM_BASE      = 16'h0000;
   localparam logic [15:0] RAM_MASK      = 16'hE000;
   localparam logic [15:0] VGA_MODE_BASE = 16'hC000;
   localparam logic [15:0] VGA_MODE_MASK = 16'hFFFC;
   localparam logic [15:0] RX_BASE       = 16'hD010;
   localparam logic [15:0] RX_MASK       = 16'hFFFE;
   localparam logic [15:0] TX_BASE       = 16'hD012;
   localparam logic [15:0] TX_MASK       = 16'hFFFE;
   localparam logic [15:0] BASIC_BASE    = 16'hE000;
   localparam logic [15:0] BASIC_MASK    = 16'hF000;
   localparam logic [15:0] WOZMON_BASE   = 16'hFF00;
   localparam logic [15:0] WOZMON_MASK   = 16'hFF00;

   localparam logic [7:0]  OPEN_BUS_DEF  = 8'hFF;

endpackage

// File: rtl/apple1_bus_ctrl_if.sv
// CPU and peripheral-slot signals of the bus controller; the controller takes
// the slave view, the CPU/peripheral side takes the master view.
interface apple1_bus_if #(
   parameter int NSLOT = 8,
   parameter int AW    = 16,
   parameter int DW    = 8
) ();
   logic                cpu_clken;
   logic [AW-1:0]       ab;
   logic                we;
   logic                cpu_ready;
   logic [DW-1:0]       dbi;
   logic [NSLOT-1:0]    slot_cs;
   logic                slot_stb;
   logic                slot_we;
   logic [NSLOT-1:0]    slot_ack;
   logic [NSLOT*DW-1:0] slot_dout;

   modport master (
      output cpu_clken, ab, we, slot_ack, slot_dout,
      input  cpu_ready, dbi, slot_cs, slot_stb, slot_we
   );

   modport slave (
      input  cpu_clken, ab, we, slot_ack, slot_dout,
      output cpu_ready, dbi, slot_cs, slot_stb, slot_we
   );
endinterface

// File: rtl/apple1_bus_ctrl_decode.sv
// Mask/match address decode with lowest-index priority; purely combinational.
module apple1_addr_decode #(
   parameter int                  NSLOT     = 8,
   parameter int                  AW        = 16,
   parameter int                  SW        = 3,
   parameter logic [NSLOT*AW-1:0] SLOT_BASE = '0,
   parameter logic [NSLOT*AW-1:0] SLOT_MASK = '0
) (
   input  logic [AW-1:0] ab_i,
   output logic [SW-1:0] sel_o,
   output logic          hit_o
);
   logic [NSLOT-1:0] hit;

   always_comb begin
      hit = '0;
      for (int i = 0; i < NSLOT; i++)
         hit[i] = ((ab_i ^ SLOT_BASE[i*AW +: AW]) & SLOT_MASK[i*AW +: AW]) == '0;
   end

   // Scan from the top so the lowest matching index is written last.
   always_comb begin
      sel_o = '0;
      for (int i = NSLOT - 1; i >= 0; i--)
         if (hit[i]) sel_o = SW'(i);
   end

   assign hit_o = |hit;

endmodule

// File: rtl/apple1_bus_ctrl.sv
// CPU-side bus controller for the Apple-1 core: slot decode, wait-state and ack
// stalling of the 6502 via ready, timeout/unmapped error capture, read mux.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | decode live address; zero-wait accesses complete here
//   ST_WAIT | CPU stalled on latched slot until wait/ack done or timeout
module apple1_bus_ctrl
   import apple1_bus_pkg::*;
#(
   parameter int                  NSLOT     = 8,
   parameter int                  AW        = 16,
   parameter int                  DW        = 8,
   parameter logic [NSLOT*AW-1:0] SLOT_BASE = '0,
   parameter logic [NSLOT*AW-1:0] SLOT_MASK = '0,
   parameter logic [NSLOT*4-1:0]  SLOT_WAIT = '0,
   parameter logic [NSLOT-1:0]    SLOT_ACK  = '0,
   parameter int                  TIMEOUT   = 15,
   parameter logic [DW-1:0]       OPEN_BUS  = DW'(OPEN_BUS_DEF)
) (
   input  logic          clk25,
   input  logic          rst_n,
   apple1_bus_if.slave   bus,
   input  logic          err_clr,
   output logic          bus_err,
   output logic [AW-1:0] err_addr
);
   localparam int SW = (NSLOT > 1) ? $clog2(NSLOT) : 1;
   localparam int TW = $clog2(TIMEOUT + 1);

   if (NSLOT < 1 || NSLOT > 16) begin : g_bad_nslot
      $error("apple1_bus_ctrl: NSLOT must be 1..16");
   end
   if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
      $error("apple1_bus_ctrl: TIMEOUT must be 1..255");
   end
   for (genvar g = 0; g < NSLOT; g++) begin : g_wait_chk
      if (SLOT_WAIT[g*4 +: 4] > TIMEOUT) begin : g_bad_wait
         $error("apple1_bus_ctrl: SLOT_WAIT exceeds TIMEOUT");
      end
   end

   state_t         state_q, state_d;
   logic [SW-1:0]  sel_q, sel_d, dec_sel, cur_sel;
   logic [AW-1:0]  alat_q, alat_d, err_at;
   logic [3:0]     wcnt_q, wcnt_d, wcnt_dec;
   logic [TW-1:0]  tcnt_q, tcnt_d, tcnt_inc;
   logic           err_q, err_d;
   logic [AW-1:0]  eaddr_q, eaddr_d;
   logic           dec_hit, cs_en, open_bus, stb, rdy, err_set, done;

   apple1_addr_decode #(
      .NSLOT     (NSLOT),
      .AW        (AW),
      .SW        (SW),
      .SLOT_BASE (SLOT_BASE),
      .SLOT_MASK (SLOT_MASK)
   ) u_decode (
      .ab_i  (bus.ab),
      .sel_o (dec_sel),
      .hit_o (dec_hit)
   );

   assign wcnt_dec = (wcnt_q == 4'd0) ? 4'd0 : wcnt_q - 4'd1;
   assign tcnt_inc = tcnt_q + 1'b1;
   // Completion looks at the post-tick count so WAIT=n releases on tick n after entry.
   assign done     = (wcnt_dec == 4'd0) && (!SLOT_ACK[sel_q] || bus.slot_ack[sel_q]);

   always_comb begin
      state_d  = state_q;
      sel_d    = sel_q;
      alat_d   = alat_q;
      wcnt_d   = wcnt_q;
      tcnt_d   = tcnt_q;
      cur_sel  = dec_sel;
      cs_en    = dec_hit;
      open_bus = !dec_hit;
      stb      = 1'b0;
      rdy      = bus.cpu_clken;
      err_set  = 1'b0;
      err_at   = bus.ab;
      unique case (state_q)
         ST_IDLE: begin
            // Held in reset the controller must not start or commit anything.
            if (bus.cpu_clken && rst_n) begin
               if (!dec_hit) begin
                  err_set = !bus.we;
               end else if (SLOT_WAIT[dec_sel*4 +: 4] == 4'd0 && !SLOT_ACK[dec_sel]) begin
                  stb = 1'b1;
               end else begin
                  rdy     = 1'b0;
                  state_d = ST_WAIT;
                  sel_d   = dec_sel;
                  alat_d  = bus.ab;
                  wcnt_d  = SLOT_WAIT[dec_sel*4 +: 4];
                  tcnt_d  = '0;
               end
            end
         end
         ST_WAIT: begin
            cur_sel  = sel_q;
            cs_en    = 1'b1;
            open_bus = 1'b0;
            rdy      = 1'b0;
            if (bus.cpu_clken) begin
               wcnt_d = wcnt_dec;
               tcnt_d = tcnt_inc;
               if (done) begin
                  stb     = 1'b1;
                  rdy     = 1'b1;
                  state_d = ST_IDLE;
               end else if (tcnt_inc == TW'(TIMEOUT)) begin
                  rdy      = 1'b1;
                  open_bus = 1'b1;
                  err_set  = 1'b1;
                  err_at   = alat_q;
                  state_d  = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      err_d   = err_q;
      eaddr_d = eaddr_q;
      if (err_clr) begin
         err_d   = 1'b0;
         eaddr_d = '0;
      end else if (err_set) begin
         err_d = 1'b1;
         if (!err_q) eaddr_d = err_at;
      end
   end

   always_ff @(posedge clk25 or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         sel_q   <= '0;
         alat_q  <= '0;
         wcnt_q  <= '0;
         tcnt_q  <= '0;
         err_q   <= 1'b0;
         eaddr_q <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         alat_q  <= alat_d;
         wcnt_q  <= wcnt_d;
         tcnt_q  <= tcnt_d;
         err_q   <= err_d;
         eaddr_q <= eaddr_d;
      end
   end

   assign bus.cpu_ready = rdy;
   assign bus.slot_cs   = cs_en ? (NSLOT'(1) << cur_sel) : '0;
   assign bus.dbi       = open_bus ? OPEN_BUS : bus.slot_dout[cur_sel*DW +: DW];
   assign bus.slot_stb  = stb;
   assign bus.slot_we   = stb & bus.we;
   assign bus_err       = err_q;
   assign err_addr      = eaddr_q;

endmodule

// File: tb/tb_apple1_bus_ctrl.sv
// Randomized and directed checking of apple1_bus_ctrl against a tick-counting
// transaction model of the bus protocol.
module tb_apple1_bus_ctrl;
   import apple1_bus_pkg::*;

   localparam int NSLOT   = 8;
   localparam int AW      = 16;
   localparam int DW      = 8;
   localparam int TIMEOUT = 15;

   localparam logic [NSLOT*AW-1:0] BASE = {16'h8000, 16'h2000, 16'hE000, TX_BASE,
                                           RX_BASE, VGA_MODE_BASE, BASIC_BASE, RAM_BASE};
   localparam logic [NSLOT*AW-1:0] MASK = {16'hF000, 16'hE000, 16'hE000, TX_MASK,
                                           RX_MASK, VGA_MODE_MASK, BASIC_MASK, RAM_MASK};
   localparam logic [NSLOT*4-1:0]  WAITS = {4'd15, 4'd0, 4'd0, 4'd3, 4'd2, 4'd0, 4'd1, 4'd0};
   localparam logic [NSLOT-1:0]    ACKS  = 8'b0000_1100;

   logic          clk25;
   logic          rst_n;
   logic          err_clr;
   logic          bus_err;
   logic [AW-1:0] err_addr;

   apple1_bus_if #(.NSLOT(NSLOT), .AW(AW), .DW(DW)) bus ();

   apple1_bus_ctrl #(
      .NSLOT     (NSLOT),
      .AW        (AW),
      .DW        (DW),
      .SLOT_BASE (BASE),
      .SLOT_MASK (MASK),
      .SLOT_WAIT (WAITS),
      .SLOT_ACK  (ACKS),
      .TIMEOUT   (TIMEOUT),
      .OPEN_BUS  (OPEN_BUS_DEF)
   ) dut (
      .clk25    (clk25),
      .rst_n    (rst_n),
      .bus      (bus),
      .err_clr  (err_clr),
      .bus_err  (bus_err),
      .err_addr (err_addr)
   );

   initial clk25 = 1'b0;
   always #5 clk25 = ~clk25;

   int n_chk = 0;
   int n_bad = 0;
   int obs_stb, obs_low;

   // Reference model: one outstanding access, tracked by ticks since entry.
   logic          m_busy;
   int            m_slot;
   logic [AW-1:0] m_addr;
   int            m_ticks;
   logic          m_err;
   logic [AW-1:0] m_eaddr;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int ref_decode(input logic [AW-1:0] a);
      for (int i = 0; i < NSLOT; i++)
         if (((a ^ BASE[i*AW +: AW]) & MASK[i*AW +: AW]) == '0) return i;
      return -1;
   endfunction

   function automatic int slot_wait(input int s);
      return int'(WAITS[s*4 +: 4]);
   endfunction

   task automatic model_cycle();
      int               s;
      logic             e_rdy, e_stb, set_e;
      logic [NSLOT-1:0] e_cs;
      logic [DW-1:0]    e_dbi;
      logic [AW-1:0]    e_at;
      if (!rst_n) begin
         m_busy  = 1'b0;
         m_err   = 1'b0;
         m_eaddr = '0;
         chk("rst_ready", 32'(bus.cpu_ready), 32'(bus.cpu_clken));
         chk("rst_stb", 32'(bus.slot_stb), 32'd0);
         chk("rst_err", 32'(bus_err), 32'd0);
         chk("rst_eaddr", 32'(err_addr), 32'd0);
      end else begin
         chk("bus_err", 32'(bus_err), 32'(m_err));
         chk("err_addr", 32'(err_addr), 32'(m_eaddr));
         set_e = 1'b0;
         e_at  = bus.ab;
         e_stb = 1'b0;
         e_rdy = bus.cpu_clken;
         if (!m_busy) begin
            s = ref_decode(bus.ab);
            if (s < 0) begin
               e_cs  = '0;
               e_dbi = OPEN_BUS_DEF;
               if (bus.cpu_clken && !bus.we) set_e = 1'b1;
            end else begin
               e_cs  = NSLOT'(1) << s;
               e_dbi = bus.slot_dout[s*DW +: DW];
               if (bus.cpu_clken) begin
                  if (slot_wait(s) == 0 && !ACKS[s]) begin
                     e_stb = 1'b1;
                  end else begin
                     e_rdy   = 1'b0;
                     m_busy  = 1'b1;
                     m_slot  = s;
                     m_addr  = bus.ab;
                     m_ticks = 0;
                  end
               end
            end
         end else begin
            e_cs  = NSLOT'(1) << m_slot;
            e_dbi = bus.slot_dout[m_slot*DW +: DW];
            e_rdy = 1'b0;
            if (bus.cpu_clken) begin
               m_ticks++;
               if (m_ticks >= slot_wait(m_slot) && (!ACKS[m_slot] || bus.slot_ack[m_slot])) begin
                  e_stb  = 1'b1;
                  e_rdy  = 1'b1;
                  m_busy = 1'b0;
               end else if (m_ticks == TIMEOUT) begin
                  e_rdy  = 1'b1;
                  e_dbi  = OPEN_BUS_DEF;
                  set_e  = 1'b1;
                  e_at   = m_addr;
                  m_busy = 1'b0;
               end
            end
         end
         chk("ready", 32'(bus.cpu_ready), 32'(e_rdy));
         chk("slot_cs", 32'(bus.slot_cs), 32'(e_cs));
         chk("dbi", 32'(bus.dbi), 32'(e_dbi));
         chk("slot_stb", 32'(bus.slot_stb), 32'(e_stb));
         chk("slot_we", 32'(bus.slot_we), 32'(e_stb & bus.we));
         if (err_clr) begin
            m_err   = 1'b0;
            m_eaddr = '0;
         end else if (set_e) begin
            if (!m_err) m_eaddr = e_at;
            m_err = 1'b1;
         end
         obs_stb += int'(bus.slot_stb);
         if (bus.cpu_clken && !bus.cpu_ready) obs_low++;
      end
   endtask

   task automatic step(input logic rst, input logic clken, input logic [AW-1:0] a,
                       input logic w, input logic [NSLOT-1:0] ack, input logic clr);
      @(negedge clk25);
      rst_n         = rst;
      bus.cpu_clken = clken;
      bus.ab        = a;
      bus.we        = w;
      bus.slot_ack  = ack;
      bus.slot_dout = {$urandom, $urandom};
      err_clr       = clr;
      #1;
      model_cycle();
   endtask

   function automatic logic [AW-1:0] rand_addr();
      case ($urandom_range(0, 7))
         0:       return 16'h0000 | 16'($urandom_range(0, 16'h1FFF));
         1:       return 16'hD010 | 16'($urandom_range(0, 3));
         2:       return 16'hC000 | 16'($urandom_range(0, 3));
         3:       return 16'hE000 | 16'($urandom_range(0, 16'h1FFF));
         4:       return 16'h8000 | 16'($urandom_range(0, 16'h0FFF));
         5:       return 16'hA000 | 16'($urandom_range(0, 16'h1FFF));
         default: return 16'($urandom);
      endcase
   endfunction

   initial begin
      logic w_hold;
      rst_n = 1'b0; err_clr = 1'b0;
      bus.cpu_clken = 1'b0; bus.ab = '0; bus.we = 1'b0;
      bus.slot_ack = '0; bus.slot_dout = '0;
      m_busy = 1'b0; m_slot = 0; m_addr = '0; m_ticks = 0; m_err = 1'b0; m_eaddr = '0;
      obs_stb = 0; obs_low = 0;

      step(1'b0, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0);
      step(1'b0, 1'b1, 16'h0000, 1'b0, 8'h00, 1'b0);
      step(1'b1, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0);

      // Zero-wait read from RAM
      obs_stb = 0; obs_low = 0;
      step(1'b1, 1'b1, 16'h0123, 1'b0, 8'h00, 1'b0);
      chk("s1_cs", 32'(bus.slot_cs), 32'h01);
      step(1'b1, 1'b0, 16'h0123, 1'b0, 8'h00, 1'b0);
      chk("s1_stb_count", 32'(obs_stb), 32'd1);
      chk("s1_low_ticks", 32'(obs_low), 32'd0);

      // Two wait states plus ack held high
      obs_stb = 0; obs_low = 0;
      for (int k = 0; k < 20 && obs_stb == 0; k++)
         step(1'b1, 1'b1, 16'hD010, 1'b0, 8'h08, 1'b0);
      chk("s2_stb_count", 32'(obs_stb), 32'd1);
      chk("s2_low_ticks", 32'(obs_low), 32'd2);
      step(1'b1, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0);

      // Ack never arrives: abort on the 15th tick after entry
      obs_stb = 0; obs_low = 0;
      for (int k = 0; k < 16; k++) begin
         step(1'b1, 1'b1, 16'hD010, 1'b0, 8'h00, 1'b0);
         if (k == 15) chk("s3_abort_dbi", 32'(bus.dbi), 32'hFF);
      end
      chk("s3_low_ticks", 32'(obs_low), 32'd15);
      chk("s3_stb_count", 32'(obs_stb), 32'd0);
      step(1'b1, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0);
      chk("s3_bus_err", 32'(bus_err), 32'd1);
      chk("s3_err_addr", 32'(err_addr), 32'hD010);

      // Unmapped read, then unmapped write, then clear
      step(1'b1, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b1);
      step(1'b1, 1'b1, 16'hA000, 1'b0, 8'h00, 1'b0);
      chk("s4_dbi", 32'(bus.dbi), 32'hFF);
      step(1'b1, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0);
      chk("s4_err_addr", 32'(err_addr), 32'hA000);
      step(1'b1, 1'b1, 16'hB000, 1'b1, 8'h00, 1'b0);
      step(1'b1, 1'b1, 16'hB000, 1'b0, 8'h00, 1'b0);
      step(1'b1, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0);
      chk("s4_err_addr_kept", 32'(err_addr), 32'hA000);
      step(1'b1, 1'b1, 16'hA004, 1'b0, 8'h00, 1'b1);
      step(1'b1, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0);
      chk("s4_clr_wins", 32'(bus_err), 32'd0);
      chk("s4_clr_addr", 32'(err_addr), 32'd0);

      // Overlapping slots 1 and 5
      step(1'b1, 1'b0, 16'hE000, 1'b0, 8'h00, 1'b0);
      chk("s5_overlap_cs", 32'(bus.slot_cs), 32'h02);

      // Reset in the middle of a stall
      step(1'b1, 1'b1, 16'hD010, 1'b0, 8'h00, 1'b0);
      step(1'b1, 1'b1, 16'hD010, 1'b0, 8'h00, 1'b0);
      step(1'b0, 1'b1, 16'hD010, 1'b0, 8'h00, 1'b0);
      chk("s6_ready", 32'(bus.cpu_ready), 32'd1);
      obs_stb = 0;
      for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 16'hD010, 1'b0, 8'h08, 1'b0);
      chk("s6_no_stb", 32'(obs_stb), 32'd0);
      step(1'b1, 1'b1, 16'h0123, 1'b0, 8'h00, 1'b0);
      chk("s6_idle_stb", 32'(bus.slot_stb), 32'd1);

      // Randomized traffic; we is held while an access is outstanding
      w_hold = 1'b0;
      for (int k = 0; k < 4000; k++) begin
         if (!m_busy) w_hold = 1'($urandom_range(0, 1));
         step(1'($urandom_range(0, 499) != 0), 1'($urandom_range(0, 1)), rand_addr(),
              w_hold, 8'($urandom), 1'($urandom_range(0, 31) == 0));
      end

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
